// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory access port between instruction fetch (I) and
//            load/store data (D). A round-robin arbiter picks a requester in
//            IDLE, and the winner's command is latched. MR/MW are driven while
//            the port waits for ACK_N. A one-cycle DONE then goes to the owner.
//            If ACK_N never arrives, the transfer aborts with BUS_ERR.
// Ports    : CLK, RESET          - clock (rising edge), synchronous active-high reset
//            REQ_I, ADDR_I       - fetch request / address (read only)
//            REQ_D, WE_D,
//            ADDR_D, WDATA_D     - data request, store enable, address, store data
//            ACK_N               - memory acknowledge, active-low
//            MR, MW              - memory read / write strobes
//            ADDR_O, WDATA_O     - latched address / store data toward memory
//            GNT_I, GNT_D        - port ownership indicators
//            DONE_I, DONE_D      - one-cycle completion pulses
//            BUS_ERR             - one-cycle timeout pulse, coincident with DONE
//            ARB_STATE           - 0=IDLE, 1=ISSUE, 2=COMPLETE
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ_I,
    input  logic [AW-1:0] ADDR_I,
    input  logic          REQ_D,
    input  logic          WE_D,
    input  logic [AW-1:0] ADDR_D,
    input  logic [DW-1:0] WDATA_D,
    input  logic          ACK_N,
    output logic          MR,
    output logic          MW,
    output logic [AW-1:0] ADDR_O,
    output logic [DW-1:0] WDATA_O,
    output logic          GNT_I,
    output logic          GNT_D,
    output logic          DONE_I,
    output logic          DONE_D,
    output logic          BUS_ERR,
    output logic [1:0]    ARB_STATE
);

    localparam logic [1:0]    c_ST_IDLE     = 2'd0;
    localparam logic [1:0]    c_ST_ISSUE    = 2'd1;
    localparam logic [1:0]    c_ST_COMPLETE = 2'd2;

    localparam logic          c_OWN_I       = 1'b0;
    localparam logic          c_OWN_D       = 1'b1;

    localparam logic [TW-1:0] c_CNT_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] c_CNT_ONE     = {{(TW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [TW-1:0] r_cnt;
    logic          r_err;
    logic          r_last;

    logic [1:0]    w_state_nxt;
    logic          w_grant;
    logic          w_win_d;
    logic          w_timeout;

    assign w_timeout = (r_cnt == c_CNT_LAST);

    // Next-state and arbitration decision
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win_d     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (REQ_I || REQ_D) begin
                    w_grant     = 1'b1;
                    // On a tie the requester served less recently wins
                    if (REQ_I && REQ_D)
                        w_win_d = (r_last == c_OWN_I);
                    else
                        w_win_d = REQ_D;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (!ACK_N || w_timeout)
                    w_state_nxt = c_ST_COMPLETE;
            end
            c_ST_COMPLETE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so REQ/ACK_N never reach them
    always_comb begin
        MR        = 1'b0;
        MW        = 1'b0;
        GNT_I     = 1'b0;
        GNT_D     = 1'b0;
        DONE_I    = 1'b0;
        DONE_D    = 1'b0;
        BUS_ERR   = 1'b0;
        ARB_STATE = r_state;
        ADDR_O    = r_addr;
        WDATA_O   = r_wdata;
        case (r_state)
            c_ST_ISSUE: begin
                MR    = ~r_we;
                MW    = r_we;
                GNT_I = (r_owner == c_OWN_I);
                GNT_D = (r_owner == c_OWN_D);
            end
            c_ST_COMPLETE: begin
                GNT_I   = (r_owner == c_OWN_I);
                GNT_D   = (r_owner == c_OWN_D);
                DONE_I  = (r_owner == c_OWN_I);
                DONE_D  = (r_owner == c_OWN_D);
                BUS_ERR = r_err;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_owner <= c_OWN_I;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_last  <= c_OWN_I;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant) begin
                r_owner <= w_win_d;
                r_we    <= w_win_d & WE_D;
                r_addr  <= w_win_d ? ADDR_D : ADDR_I;
                r_wdata <= w_win_d ? WDATA_D : '0;
                r_cnt   <= '0;
            end

            // An acknowledge in the last allowed cycle still counts as success
            if (r_state == c_ST_ISSUE) begin
                if (!ACK_N)
                    r_err <= 1'b0;
                else if (w_timeout)
                    r_err <= 1'b1;
                else
                    r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (r_state == c_ST_COMPLETE)
                r_last <= r_owner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Each expected transfer
//            is queued when its request is driven. It is popped and compared
//            when the DUT pulses DONE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } txn_t;

    logic        CLK;
    logic        RESET;
    logic        REQ_I;
    logic [31:0] ADDR_I;
    logic        REQ_D;
    logic        WE_D;
    logic [31:0] ADDR_D;
    logic [31:0] WDATA_D;
    logic        ACK_N;
    logic        MR;
    logic        MW;
    logic [31:0] ADDR_O;
    logic [31:0] WDATA_O;
    logic        GNT_I;
    logic        GNT_D;
    logic        DONE_I;
    logic        DONE_D;
    logic        BUS_ERR;
    logic [1:0]  ARB_STATE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t sb[$];
    txn_t exp_t;

    // Observations gathered by track()
    int         t_done;
    int         t_issue;
    int         t_mr;
    int         t_mw;
    int         t_viol;
    int         t_n;
    int         t_first_issue;
    int         t_done_cyc;
    txn_t       t_got;
    logic [1:0] st_log [0:63];

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(16), .TW(5)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_I(REQ_I), .ADDR_I(ADDR_I),
        .REQ_D(REQ_D), .WE_D(WE_D), .ADDR_D(ADDR_D), .WDATA_D(WDATA_D),
        .ACK_N(ACK_N),
        .MR(MR), .MW(MW), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
        .GNT_I(GNT_I), .GNT_D(GNT_D), .DONE_I(DONE_I), .DONE_D(DONE_D),
        .BUS_ERR(BUS_ERR), .ARB_STATE(ARB_STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic txn_t mk(input logic o, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic e);
        txn_t t;
        t.owner = o; t.we = w; t.addr = a; t.wdata = d; t.err = e;
        return t;
    endfunction

    // Follows one transfer from the current negedge until DONE (bounded).
    // ACK_N is pulled low during the ack_at-th ISSUE cycle (0 = never).
    task automatic track(input int ack_at);
        t_done = 0; t_issue = 0; t_mr = 0; t_mw = 0; t_viol = 0; t_n = 0;
        t_first_issue = -1; t_done_cyc = -1; t_got = '0;
        for (int k = 0; k < 64; k++) begin
            st_log[k] = ARB_STATE;
            t_n = k + 1;
            if ((GNT_I && GNT_D) || (DONE_I && DONE_D) || (MR && MW)) t_viol++;
            if (ARB_STATE == 2'd1) begin
                if (t_issue == 0) t_first_issue = cyc;
                t_issue++;
                if (MR) t_mr++;
                if (MW) t_mw++;
                ACK_N = (ack_at != 0 && t_issue == ack_at) ? 1'b0 : 1'b1;
            end else begin
                ACK_N = 1'b1;
            end
            if (DONE_I || DONE_D) begin
                t_done     = 1;
                t_done_cyc = cyc;
                t_got      = mk(DONE_D, (t_mw != 0), ADDR_O, WDATA_O, BUS_ERR);
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ_I = 1'b0; ADDR_I = '0; REQ_D = 1'b0; WE_D = 1'b0;
        ADDR_D = '0; WDATA_D = '0; ACK_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({MR, MW, ADDR_O, WDATA_O, GNT_I, GNT_D, DONE_I, DONE_D, BUS_ERR, ARB_STATE} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got MR=%b MW=%b A=%h D=%h ST=%0d exp all zero",
                     MR, MW, ADDR_O, WDATA_O, ARB_STATE);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (ARB_STATE !== 2'd0 || GNT_I !== 1'b0 || GNT_D !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ST=%0d GNT=%b%b exp ST=0 GNT=00", ARB_STATE, GNT_I, GNT_D);
        end
    endtask

    task automatic test_fetch();
        REQ_I = 1'b1; ADDR_I = 32'h100;
        sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 1'b0));
        track(2);
        checks++;
        if (t_n != 4 || {st_log[0], st_log[1], st_log[2], st_log[3]} !== 8'b00_01_01_10) begin
            errors++;
            $display("FAIL fetch_state_seq got %0d,%0d,%0d,%0d (n=%0d) exp 0,1,1,2",
                     st_log[0], st_log[1], st_log[2], st_log[3], t_n);
        end
        checks++;
        if (t_mr != 2 || t_mw != 0 || t_viol != 0) begin
            errors++;
            $display("FAIL fetch_strobes got mr=%0d mw=%0d viol=%0d exp mr=2 mw=0 viol=0", t_mr, t_mw, t_viol);
        end
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t) begin
            errors++;
            $display("FAIL fetch_txn got %h exp %h done=%0d", t_got, exp_t, t_done);
        end
        REQ_I = 1'b0;
        @(negedge CLK);
        checks++;
        if (ARB_STATE !== 2'd0 || DONE_I !== 1'b0) begin
            errors++;
            $display("FAIL fetch_back_idle got ST=%0d DONE_I=%b exp ST=0 DONE_I=0", ARB_STATE, DONE_I);
        end
    endtask

    task automatic test_store();
        REQ_D = 1'b1; WE_D = 1'b1; ADDR_D = 32'h2000; WDATA_D = 32'hDEADBEEF;
        sb.push_back(mk(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0));
        track(1);
        checks++;
        if (t_mw != 1 || t_mr != 0 || t_viol != 0 || (t_done_cyc - t_first_issue) != 1) begin
            errors++;
            $display("FAIL store_strobes got mw=%0d mr=%0d viol=%0d lat=%0d exp mw=1 mr=0 viol=0 lat=1",
                     t_mw, t_mr, t_viol, t_done_cyc - t_first_issue);
        end
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t) begin
            errors++;
            $display("FAIL store_txn got %h exp %h done=%0d", t_got, exp_t, t_done);
        end
        REQ_D = 1'b0; WE_D = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int prev_done;
        prev_done = 0;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        REQ_I = 1'b1; REQ_D = 1'b1; WE_D = 1'b0;
        ADDR_I = 32'h10; ADDR_D = 32'h20; WDATA_D = 32'h55;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back(mk(1'b1, 1'b0, 32'h20, 32'h55, 1'b0));
            else            sb.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 1'b0));
        end
        for (int i = 0; i < 4; i++) begin
            track(1);
            if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
            checks++;
            if (t_done == 0 || t_got !== exp_t || t_viol != 0) begin
                errors++;
                $display("FAIL tie_txn%0d got %h exp %h done=%0d viol=%0d", i, t_got, exp_t, t_done, t_viol);
            end
            if (i > 0) begin
                checks++;
                if (t_first_issue - prev_done != 2) begin
                    errors++;
                    $display("FAIL tie_gap%0d got %0d exp 2", i, t_first_issue - prev_done);
                end
            end
            prev_done = t_done_cyc;
            if (i == 3) begin
                REQ_I = 1'b0; REQ_D = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_timeout();
        REQ_I = 1'b1; ADDR_I = 32'h400;
        sb.push_back(mk(1'b0, 1'b0, 32'h400, 32'h0, 1'b1));
        track(0);
        checks++;
        if (t_mr != 16 || t_issue != 16) begin
            errors++;
            $display("FAIL timeout_len got mr=%0d issue=%0d exp 16", t_mr, t_issue);
        end
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t) begin
            errors++;
            $display("FAIL timeout_txn got %h exp %h done=%0d", t_got, exp_t, t_done);
        end
        ADDR_I = 32'h404;
        @(negedge CLK);
        checks++;
        if (ARB_STATE !== 2'd0 || BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got ST=%0d ERR=%b exp ST=0 ERR=0", ARB_STATE, BUS_ERR);
        end
        // REQ_I held: a fresh transfer, acknowledged in the last allowed cycle
        sb.push_back(mk(1'b0, 1'b0, 32'h404, 32'h0, 1'b0));
        track(16);
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t || t_issue != 16) begin
            errors++;
            $display("FAIL late_ack_txn got %h exp %h issue=%0d", t_got, exp_t, t_issue);
        end
        REQ_I = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_robust();
        int bad;
        bad = 0;
        REQ_D = 1'b1; WE_D = 1'b0; ADDR_D = 32'h3000; WDATA_D = 32'h1234;
        sb.push_back(mk(1'b1, 1'b0, 32'h3000, 32'h1234, 1'b0));
        @(negedge CLK);
        checks++;
        if (ARB_STATE !== 2'd1 || GNT_D !== 1'b1) begin
            errors++;
            $display("FAIL robust_grant got ST=%0d GNT_D=%b exp ST=1 GNT_D=1", ARB_STATE, GNT_D);
        end
        REQ_D = 1'b0; ADDR_D = 32'hFFFF; WDATA_D = 32'h0;
        track(2);
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t) begin
            errors++;
            $display("FAIL robust_txn got %h exp %h done=%0d", t_got, exp_t, t_done);
        end
        @(negedge CLK);
        ACK_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (ARB_STATE !== 2'd0 || DONE_I || DONE_D || MR || MW) bad++;
        end
        ACK_N = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_ack_ignored got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        REQ_I = 1'b1; ADDR_I = 32'h500; ACK_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (ARB_STATE !== 2'd1 || MR !== 1'b1 || GNT_I !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue got ST=%0d MR=%b GNT_I=%b exp ST=1 MR=1 GNT_I=1", ARB_STATE, MR, GNT_I);
        end
        RESET = 1'b1;
        REQ_D = 1'b1; WE_D = 1'b0; ADDR_D = 32'h600; WDATA_D = 32'h77;
        @(negedge CLK);
        checks++;
        if ({MR, MW, GNT_I, GNT_D, DONE_I, DONE_D, BUS_ERR, ARB_STATE} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid got MR=%b MW=%b GNT=%b%b DONE=%b%b ST=%0d exp all zero",
                     MR, MW, GNT_I, GNT_D, DONE_I, DONE_D, ARB_STATE);
        end
        RESET = 1'b0;
        sb.push_back(mk(1'b1, 1'b0, 32'h600, 32'h77, 1'b0));
        track(1);
        if (sb.size() != 0) exp_t = sb.pop_front(); else exp_t = '1;
        checks++;
        if (t_done == 0 || t_got !== exp_t) begin
            errors++;
            $display("FAIL reset_release_txn got %h exp %h done=%0d", t_got, exp_t, t_done);
        end
        REQ_I = 1'b0; REQ_D = 1'b0;
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_robust();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory access control state machine between two requesters: instruction fetch (I) and load/store data (D).
- Arbitrates with round-robin on ties, then latches the winner's command and drives MR/MW/address/write-data toward the memory bus.
- Watches ACK_N, returns a one-cycle DONE to the owner, and aborts with BUS_ERR if ACK_N never arrives.
- Sits between the DLX pipeline control and the memory access controller.

Parameters:
AW, 32, address width
DW, 32, write-data width
TIMEOUT, 16, max cycles spent in ISSUE before abort (legal range >= 2)
TW, 5, timeout counter width (must hold TIMEOUT-1)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high
REQ_I  in  1  fetch request; held high until DONE_I
ADDR_I  in  AW  fetch address (read only)
REQ_D  in  1  data request; held high until DONE_D
WE_D  in  1  1=store, 0=load
ADDR_D  in  AW  data address
WDATA_D  in  DW  store data
ACK_N  in  1  memory acknowledge, active-low
MR  out  1  memory read strobe
MW  out  1  memory write strobe
ADDR_O  out  AW  latched address to memory
WDATA_O  out  DW  latched store data
GNT_I  out  1  fetch owns the port
GNT_D  out  1  data owns the port
DONE_I  out  1  one-cycle fetch completion pulse
DONE_D  out  1  one-cycle data completion pulse
BUS_ERR  out  1  one-cycle pulse, coincident with DONE, on timeout
ARB_STATE  out  2  0=IDLE, 1=ISSUE, 2=COMPLETE

Behaviour:
- Reset values: state IDLE; all outputs 0; ADDR_O/WDATA_O = 0; last_served = I (so the first tie goes to D); counter = 0.
- IDLE:
  - no REQ: stay in IDLE.
  - single REQ: that requester wins.
  - both REQ: winner = requester not equal to last_served.
  - On a win, at the same edge: latch owner, we (WE_D for D, 0 for I), ADDR, and WDATA (WDATA_D, or 0 for I); clear counter; go to ISSUE.
- ISSUE:
  - Outputs: MR = ~we_lat, MW = we_lat; GNT of owner = 1.
  - ACK_N=0: go to COMPLETE, err_lat=0.
  - ACK_N=1 and counter==TIMEOUT-1: go to COMPLETE, err_lat=1.
  - Otherwise: counter++, stay in ISSUE.
  - ACK_N=0 takes priority over timeout in the same cycle.
- COMPLETE (exactly 1 cycle):
  - MR=MW=0; GNT of owner stays 1; DONE of owner = 1; BUS_ERR = err_lat.
  - Update last_served = owner; go to IDLE.
- Minimum transfer: IDLE, ISSUE (ACK at the first ISSUE cycle), COMPLETE = 3 cycles. Next grant is available in the IDLE cycle after COMPLETE.
- Outputs are decoded only from registered state, owner, and latches; no combinational path from REQ or ACK_N to any output.
- Request inputs are ignored outside IDLE.
  - A REQ dropped mid-transfer does not abort; the transfer completes and DONE still pulses.
  - ADDR/WDATA changes after the grant have no effect.
- A requester that keeps REQ high after DONE is treated as a new request in IDLE.
- GNT_I and GNT_D are never both 1. DONE_I and DONE_D are never both 1. MR and MW are never both 1.
- RESET mid-transfer: next edge forces IDLE; MR/MW/GNT drop that cycle; no DONE is issued; last_served returns to I.
- ACK_N low while in IDLE or COMPLETE is ignored.

Test Plan:
- Single fetch: REQ_I=1, ADDR_I=0x100, ACK_N low on the 2nd ISSUE cycle -> MR=1 for 2 cycles, ADDR_O=0x100, MW=0, DONE_I pulses 1 cycle later, ARB_STATE sequence 0,1,1,2,0.
- Store: REQ_D=1, WE_D=1, ADDR_D=0x2000, WDATA_D=0xDEADBEEF, ACK_N low at once -> MW=1 for 1 cycle, WDATA_O=0xDEADBEEF, DONE_D next cycle, BUS_ERR=0.
- Tie after reset: REQ_I=REQ_D=1 held, ACK_N immediate each time -> grants in order D, I, D, I, with each DONE followed by the next ISSUE 2 cycles later.
- Timeout: REQ_I=1, ACK_N held 1 -> MR high exactly 16 cycles, then DONE_I=1 and BUS_ERR=1 together, then IDLE. A variant drops ACK_N on ISSUE cycle 16 -> DONE_I with BUS_ERR=0.
- Robustness: REQ_D drops and ADDR_D changes mid-ISSUE -> ADDR_O unchanged, DONE_D still pulses after ACK_N. ACK_N=0 in IDLE -> no state change.
- Reset mid-transfer: RESET at the 3rd ISSUE cycle -> MR=0, GNT=0 the next cycle, no DONE, ARB_STATE=0. On release with both REQ high, D wins first.
